// File: rtl/vga_txt_pkg.sv
// Shared constants and sideband types for the VGA text path
// (also used by the timing generator).
package vga_txt_pkg;

    localparam int CHAR_W          = 8;
    localparam int CHAR_H          = 16;
    localparam int LATENCY         = 6;
    localparam int RAM_AW          = 11;
    localparam int FONT_AW         = 12;
    localparam int CURSOR_SL_FIRST = 14;

    // Per-pixel information needed at the serialiser stage
    typedef struct packed {
        logic       in_area;
        logic       cur_hit;
        logic [2:0] px;
    } pix_side_t;

    // Per-pixel information needed up to the font-address stage
    typedef struct packed {
        pix_side_t  pix;
        logic [3:0] sl;
    } side_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay line with synchronous active-low reset.
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_q [DEPTH];
    logic [WIDTH-1:0] pipe_d [DEPTH];

    // Next state: shift every tap one stage along
    always_comb begin
        pipe_d[0] = din;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Stage registers, cleared by reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_text_fetch.sv
// Character-cell scan-out: pixel coordinates -> text buffer -> font ROM ->
// one mono pixel, with frame-latched blinking cursor and matched sync delay.
module vga_text_fetch
    import vga_txt_pkg::*;
#(
    parameter int COLS       = 80,
    parameter int ROWS       = 25,
    parameter int BLINK_LOG2 = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               de_in,
    input  logic               hs_in,
    input  logic               vs_in,
    input  logic [9:0]         x_in,
    input  logic [9:0]         y_in,
    input  logic               cursor_en,
    input  logic [6:0]         cursor_col,
    input  logic [4:0]         cursor_row,
    output logic [RAM_AW-1:0]  ram_adb,
    output logic               ram_ceb,
    output logic               ram_oce,
    output logic               ram_resetb,
    input  logic [7:0]         ram_dout,
    output logic [FONT_AW-1:0] font_ad,
    output logic               font_ce,
    input  logic [7:0]         font_dout,
    output logic               pix_out,
    output logic               de_out,
    output logic               hs_out,
    output logic               vs_out
);

    // Sideband reaches the font stage together with ram_dout (after 3 clocks),
    // then the serialiser stage together with font_dout (2 more clocks).
    localparam int unsigned SB1_DEPTH = 3;
    localparam int unsigned SB2_DEPTH = LATENCY - SB1_DEPTH - 1;

    logic [6:0]        col;
    logic [2:0]        px;
    logic [5:0]        row;
    logic [3:0]        sl;
    logic              in_area;
    logic              cur_hit;
    logic [RAM_AW-1:0] cell_addr;
    side_t             s0, s3;
    pix_side_t         s5;
    logic [2:0]        sync_out;
    logic              vs_rise;

    logic [RAM_AW-1:0]     ram_adb_q, ram_adb_d;
    logic                  ram_ceb_q, ram_ceb_d;
    logic [FONT_AW-1:0]    font_ad_q, font_ad_d;
    logic                  font_ce_q, font_ce_d;
    logic                  pix_q, pix_d;
    logic                  vs_prev_q, vs_prev_d;
    logic [BLINK_LOG2-1:0] blink_q, blink_d;
    logic                  cur_en_f_q, cur_en_f_d;
    logic [6:0]            cur_col_f_q, cur_col_f_d;
    logic [4:0]            cur_row_f_q, cur_row_f_d;

    // Cell decode, buffer address and cursor hit for the incoming pixel
    always_comb begin
        col       = x_in[9:3];
        px        = x_in[2:0];
        row       = y_in[9:4];
        sl        = y_in[3:0];
        in_area   = de_in & ({1'b0, col} < 8'(COLS)) & ({1'b0, row} < 7'(ROWS));
        cell_addr = RAM_AW'(row) * RAM_AW'(COLS) + RAM_AW'(col);
        cur_hit   = cur_en_f_q & blink_q[BLINK_LOG2-1] & (col == cur_col_f_q) &
                    (row == {1'b0, cur_row_f_q}) & (sl >= 4'(CURSOR_SL_FIRST));
        s0.pix.in_area = in_area;
        s0.pix.cur_hit = cur_hit;
        s0.pix.px      = px;
        s0.sl          = sl;
    end

    // Cursor state and blink counter only change on a vs_in rising edge
    always_comb begin
        vs_rise     = vs_in & ~vs_prev_q;
        vs_prev_d   = vs_in;
        blink_d     = vs_rise ? blink_q + 1'b1 : blink_q;
        cur_en_f_d  = vs_rise ? cursor_en  : cur_en_f_q;
        cur_col_f_d = vs_rise ? cursor_col : cur_col_f_q;
        cur_row_f_d = vs_rise ? cursor_row : cur_row_f_q;
    end

    // Data pipeline: buffer address (S1), font address (S4), pixel (S6)
    always_comb begin
        ram_adb_d = in_area ? cell_addr : ram_adb_q;
        ram_ceb_d = in_area;
        font_ad_d = s3.pix.in_area ? {ram_dout, s3.sl} : font_ad_q;
        font_ce_d = s3.pix.in_area;
        pix_d     = s5.in_area & (font_dout[3'd7 - s5.px] ^ s5.cur_hit);
    end

    // All registered state, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ram_adb_q   <= '0;
            ram_ceb_q   <= 1'b0;
            font_ad_q   <= '0;
            font_ce_q   <= 1'b0;
            pix_q       <= 1'b0;
            vs_prev_q   <= 1'b0;
            blink_q     <= '0;
            cur_en_f_q  <= 1'b0;
            cur_col_f_q <= '0;
            cur_row_f_q <= '0;
        end else begin
            ram_adb_q   <= ram_adb_d;
            ram_ceb_q   <= ram_ceb_d;
            font_ad_q   <= font_ad_d;
            font_ce_q   <= font_ce_d;
            pix_q       <= pix_d;
            vs_prev_q   <= vs_prev_d;
            blink_q     <= blink_d;
            cur_en_f_q  <= cur_en_f_d;
            cur_col_f_q <= cur_col_f_d;
            cur_row_f_q <= cur_row_f_d;
        end
    end

    vga_delay_line #(.WIDTH(3), .DEPTH(LATENCY)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     ({de_in, hs_in, vs_in}),
        .dout    (sync_out)
    );

    vga_delay_line #(.WIDTH($bits(side_t)), .DEPTH(SB1_DEPTH)) u_side_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (s0),
        .dout    (s3)
    );

    vga_delay_line #(.WIDTH($bits(pix_side_t)), .DEPTH(SB2_DEPTH)) u_side_font (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (s3.pix),
        .dout    (s5)
    );

    assign ram_adb    = ram_adb_q;
    assign ram_ceb    = ram_ceb_q;
    assign ram_oce    = ram_ceb_q;
    assign ram_resetb = ~reset_n;
    assign font_ad    = font_ad_q;
    assign font_ce    = font_ce_q;
    assign pix_out    = pix_q;
    assign de_out     = sync_out[2];
    assign hs_out     = sync_out[1];
    assign vs_out     = sync_out[0];

endmodule

// File: doc/vga_text_fetch.md
# vga_text_fetch

Character-cell scan-out engine for the VGA text controller. It is the read side of the 2048×8 text buffer: the host writes character codes through port A, and this block reads them through port B. For each pixel it turns the timing generator's coordinates into a buffer address, looks up the glyph byte in the font ROM, and serialises one mono pixel. Cursor overlay and blink are included. It sits between the timing generator and the colour/output stage, and delays the sync/DE signals to match its pipeline.

## Interface
- COLS, 80: character columns; the cell area is COLS×8 pixels wide.
- ROWS, 25: character rows; the cell area is ROWS×16 lines tall. COLS×ROWS must be ≤ 2048.
- BLINK_LOG2, 5: the blink counter width; the cursor phase toggles every 2^(BLINK_LOG2-1) frames.
- clk  in  1  pixel clock; the only clock.
- reset_n  in  1  reset, synchronous, active-low.
- de_in / hs_in / vs_in  in  1 each  display enable and syncs from the timing generator, active-high.
- x_in  in  10  pixel column; y_in  in  10  pixel line.
- cursor_en  in  1  cursor visible; cursor_col  in  7, cursor_row  in  5  cursor cell.
- ram_adb  out  11  text buffer read address.
- ram_ceb  out  1  read clock enable; ram_oce  out  1  output-register enable.
- ram_resetb  out  1  read-port reset, equal to ~reset_n.
- ram_dout  in  8  character code; the buffer port is pipelined, so data arrives 2 clocks after the address.
- font_ad  out  12  glyph address {char[7:0], scanline[3:0]}; font_ce  out  1.
- font_dout  in  8  glyph byte, 1 clock after font_ad; bit 7 is the leftmost pixel.
- pix_out  out  1  pixel on; de_out / hs_out / vs_out  out  1 each  inputs delayed by LATENCY.

## Operation
- Cell decode:
  - col = x_in[9:3], px = x_in[2:0], row = y_in[9:4], sl = y_in[3:0].
  - in_area = de_in & (col < COLS) & (row < ROWS).
  - Address = row*COLS + col, held to 11 bits. COLS is a constant, so this is a constant multiply.
- Pipeline, six registered stages:
  - S1: ram_adb. ram_ceb = ram_oce = in_area of that sample.
  - S2: the RAM address is captured.
  - S3: ram_dout is valid.
  - S4: font_ad = {ram_dout, sl}; font_ce = 1.
  - S5: font_dout is valid.
  - S6: pix_out.
  - A sideband shift register carries in_area, px, and the cursor hit alongside the data.
- Pixel: pix_out = in_area & (font_dout[7-px] XOR cur_hit).
- Cursor hit: cur_hit = cursor_en_f & blink & (col==cursor_col_f) & (row==cursor_row_f) & (sl ≥ 14).
- Frame latch: on the rising edge of vs_in, cursor_en/col/row are latched into the *_f registers and the blink counter increments. Blink = counter MSB. The cursor therefore never tears mid-frame.
- Outside the cell area (border, blanking): ram_ceb and font_ce are 0 and pix_out is 0. ram_adb and font_ad hold their last values.
- No state machine beyond the pipeline. There are no handshakes and no back-pressure: one pixel in and one pixel out every clock.

## Timing
- LATENCY = 6 clocks from de_in/hs_in/vs_in/x_in/y_in to pix_out/de_out/hs_out/vs_out. All four outputs are aligned.
- Reset (reset_n low at a clock edge) clears everything to 0: every output except ram_resetb, all pipeline and sideband registers, the blink counter, and the latched cursor.
- ram_resetb = ~reset_n combinationally, so it is 1 during reset.
- Reset mid-frame: outputs are 0 while reset is held. The first valid pixel appears 6 clocks after the first sampled input following release. The cursor stays hidden until the first vs_in rising edge.
- Blink wrap: the counter rolls over from all-ones to 0. This is legal and gives a continuous phase.
- Address boundary: the last cell (row ROWS-1, col COLS-1) gives 1999 for 80×25. Any col ≥ COLS is suppressed by in_area, so no aliased read occurs.
- A cursor set to an out-of-area cell never hits.
- Any change to cursor_* mid-frame takes effect only at the next vs_in rising edge.

## Structure
- Shared package vga_txt_pkg:
  - CHAR_W=8, CHAR_H=16, LATENCY=6;
  - RAM_AW=11, FONT_AW=12;
  - CURSOR_SL_FIRST=14.
  - The timing generator also uses this package.
- Sub-module vga_delay_line (parameters WIDTH and DEPTH, synchronous active-low reset) carries the sync/DE/sideband bits. Everything else stays in this one file.

## Test plan
- Buffer holds 0x41 at address 0 and the font ROM model gives 'A' scanline 0 = 0x18. Scan x=0..7, y=0 → pix_out = 0,0,0,1,1,0,0,0, starting 6 clocks after x=0.
- x=639, y=399 (last cell) → ram_adb=1999 with ram_ceb=1. x=0, y=400 → ram_ceb=0, font_ce=0, pix_out=0.
- Cursor at (col 3, row 2) with cursor_en=1, after 16 vs_in rising edges (blink=1) → cell lines 46–47, x=24..31 are inverted. Lines 32–45 are unchanged. After 32 edges the cursor is hidden again.
- cursor_col changes mid-frame → no change until the next vs_in rising edge. From then on, the new position is used.
- de_in toggling with a random pattern → de_out equals de_in delayed by exactly 6 clocks. hs_out and vs_out are likewise exact.
- reset_n pulled low mid-line for 3 clocks → all outputs 0 during reset, ram_resetb=1, and the blink counter reads 0. Correct pixels resume 6 clocks after release.
